// File: rtl/top_pkg.sv
// Shared constants and FSM state type for the serial ADC frame reader.
package top_pkg;

    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_DATA_BITS  = 12;
    localparam int unsigned ADC_LEAD_ZEROS = 4;

    localparam int unsigned BIT_CNT_W   = 5;
    localparam int unsigned QUIET_CNT_W = 10;
    localparam int unsigned DIV_CNT_W   = 8;
    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic {
        QUIET = 1'b0,
        FRAME = 1'b1
    } adc_state_e;

endpackage

// File: rtl/adc_clk_gen.sv
// ADC serial clock divider: idles high while disabled, toggles every CLK_DIV
// cycles while enabled, and flags the cycle in which each edge is launched.
module adc_clk_gen
    import top_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_adc_clk,
    output logic o_rise_c,
    output logic o_fall_c
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

    logic [DIV_CNT_W-1:0] r_div;
    logic                 r_adc_clk;
    logic                 w_toggle;

    // Strobes are high in the cycle before the registered level changes.
    assign w_toggle  = i_en && (r_div == DIV_LAST);
    assign o_rise_c  = w_toggle && !r_adc_clk;
    assign o_fall_c  = w_toggle && r_adc_clk;
    assign o_adc_clk = r_adc_clk;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div     <= '0;
            r_adc_clk <= 1'b1;
        end else if (!i_en) begin
            r_div     <= '0;
            r_adc_clk <= 1'b1;
        end else if (w_toggle) begin
            r_div     <= '0;
            r_adc_clk <= ~r_adc_clk;
        end else begin
            r_div     <= r_div + DIV_CNT_W'(1);
        end
    end

endmodule

// File: rtl/top.sv
// Free-running serial ADC reader: QUIET/FRAME sequencer, adc_sd synchronizer
// and 16-bit capture shift register feeding a registered 12-bit sample.
module top
    import top_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned QUIET_CLKS = 16
) (
    input  logic                     clock_in,
    input  logic                     reset,
    output logic                     adc_cs,
    output logic                     adc_clk,
    input  logic                     adc_sd,
    output logic [ADC_DATA_BITS-1:0] sample,
    output logic                     sample_valid
);

    localparam logic [QUIET_CNT_W-1:0] QUIET_LAST = QUIET_CNT_W'(QUIET_CLKS - 1);
    localparam logic [BIT_CNT_W-1:0]   BIT_LAST   = BIT_CNT_W'(ADC_FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]   BIT_SAT    = BIT_CNT_W'(ADC_FRAME_BITS);

    adc_state_e                r_state;
    adc_state_e                w_state_nxt;
    logic [QUIET_CNT_W-1:0]    r_quiet_cnt;
    logic [BIT_CNT_W-1:0]      r_bit_cnt;
    logic [SYNC_STAGES-1:0]    r_sd_sync;
    logic [SYNC_STAGES-1:0]    r_rise_d;
    logic [SYNC_STAGES:0]      r_last_d;
    logic [ADC_FRAME_BITS-1:0] r_shift;
    logic                      r_adc_cs;
    logic [ADC_DATA_BITS-1:0]  r_sample;
    logic                      r_sample_valid;

    logic w_frame_en;
    logic w_rise;
    logic w_fall;
    logic w_last_rise;
    logic w_adc_clk;
    logic w_unused;

    assign w_frame_en  = (r_state == FRAME);
    assign w_last_rise = w_rise && (r_bit_cnt == BIT_LAST);

    adc_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_adc_clk_gen (
        .i_clk     (clock_in),
        .i_rst_n   (reset),
        .i_en      (w_frame_en),
        .o_adc_clk (w_adc_clk),
        .o_rise_c  (w_rise),
        .o_fall_c  (w_fall)
    );

    // Leading frame bits are dropped unchecked; the fall strobe is not needed here.
    assign w_unused = ^{w_fall, r_shift[ADC_FRAME_BITS-1 -: ADC_LEAD_ZEROS]};

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_state <= QUIET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            QUIET:   if (r_quiet_cnt == QUIET_LAST) w_state_nxt = FRAME;
            FRAME:   if (w_last_rise)               w_state_nxt = QUIET;
            default: w_state_nxt = QUIET;
        endcase
    end

    // Quiet-gap timer and saturating rising-edge counter.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_quiet_cnt <= '0;
            r_bit_cnt   <= '0;
        end else begin
            if ((r_state == QUIET) && (w_state_nxt == QUIET)) begin
                r_quiet_cnt <= r_quiet_cnt + QUIET_CNT_W'(1);
            end else begin
                r_quiet_cnt <= '0;
            end

            if (r_state != FRAME) begin
                r_bit_cnt <= '0;
            end else if (w_rise && (r_bit_cnt != BIT_SAT)) begin
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

    // The rise strobe is delayed by the synchronizer depth so each shift takes
    // the adc_sd value that was present at the rising adc_clk edge; the sample
    // commits one cycle after the last shift.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_sd_sync <= '0;
            r_rise_d  <= '0;
            r_last_d  <= '0;
            r_shift   <= '0;
        end else begin
            r_sd_sync <= {r_sd_sync[SYNC_STAGES-2:0], adc_sd};
            r_rise_d  <= {r_rise_d[SYNC_STAGES-2:0], w_rise};
            r_last_d  <= {r_last_d[SYNC_STAGES-1:0], w_last_rise};
            if (r_rise_d[SYNC_STAGES-1]) begin
                r_shift <= {r_shift[ADC_FRAME_BITS-2:0], r_sd_sync[SYNC_STAGES-1]};
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_adc_cs       <= 1'b1;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_adc_cs       <= (w_state_nxt != FRAME);
            r_sample_valid <= r_last_d[SYNC_STAGES];
            if (r_last_d[SYNC_STAGES]) begin
                r_sample <= r_shift[ADC_DATA_BITS-1:0];
            end
        end
    end

    assign adc_cs       = r_adc_cs;
    assign adc_clk      = w_adc_clk;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_top.sv
// Bench for top: a default-parameter instance runs table, random and abort
// sequences; a CLK_DIV=1/QUIET_CLKS=1 instance runs a 1000-frame ramp.
module tb_top;

    typedef struct {
        logic [15:0] word;
        logic [11:0] exp;
    } vec_t;

    logic        clock_in = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        cs_a, clk_a, valid_a;
    logic        cs_b, clk_b, valid_b;
    logic        sd_a = 1'bx;
    logic        sd_b = 1'bx;
    logic [11:0] sample_a, sample_b;

    int checks = 0;
    int errors = 0;

    always #5 clock_in = ~clock_in;

    top #(.CLK_DIV(4), .QUIET_CLKS(16)) u_dut_a (
        .clock_in     (clock_in),
        .reset        (rst_a),
        .adc_cs       (cs_a),
        .adc_clk      (clk_a),
        .adc_sd       (sd_a),
        .sample       (sample_a),
        .sample_valid (valid_a)
    );

    top #(.CLK_DIV(1), .QUIET_CLKS(1)) u_dut_b (
        .clock_in     (clock_in),
        .reset        (rst_b),
        .adc_cs       (cs_b),
        .adc_clk      (clk_b),
        .adc_sd       (sd_b),
        .sample       (sample_b),
        .sample_valid (valid_b)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    function automatic void fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event within cycle budget", name);
    endfunction

    // Serial slaves: MSB first, new bit shortly after each falling adc_clk, X while deselected.
    logic [15:0] a_word = 16'h0000;
    logic [15:0] b_word = 16'h0000;
    int          b_frame_idx = 0;
    logic [11:0] b_exp[$];

    always begin : slave_a
        @(negedge cs_a);
        for (int k = 15; k >= 0; k--) begin
            @(negedge clk_a or posedge cs_a);
            if (cs_a) break;
            #1 sd_a = a_word[k];
        end
        if (!cs_a) @(posedge cs_a);
        #1 sd_a = 1'bx;
    end

    always begin : slave_b
        @(negedge cs_b);
        b_word = 16'(b_frame_idx);
        b_frame_idx++;
        for (int k = 15; k >= 0; k--) begin
            @(negedge clk_b or posedge cs_b);
            if (cs_b) break;
            #1 sd_b = b_word[k];
        end
        if (!cs_b) @(posedge cs_b);
        if (rst_b) b_exp.push_back(12'(b_word % 16'd4096));
        #1 sd_b = 1'bx;
    end

    // Protocol monitor for instance A (CLK_DIV=4, QUIET_CLKS=16).
    int   a_cyc = 0, a_rises = 0, a_last_rise = 0, a_valid_cnt = 0;
    bit   a_len_ok = 0, a_win_ok = 0;
    logic a_cs_q = 1'b1, a_clk_q = 1'b1, a_v_q = 1'b0;

    always @(negedge clock_in) begin
        if (!rst_a) begin
            a_len_ok = 0; a_win_ok = 0;
            a_cs_q = 1'b1; a_clk_q = 1'b1; a_v_q = 1'b0;
        end else begin
            a_cyc++;
            if (a_cs_q && !cs_a) begin
                if (a_len_ok) check("a_frame_len", 32'(a_cyc), 32'd144);
                a_cyc = 0; a_len_ok = 1; a_rises = 0; a_win_ok = 1;
            end
            if (!a_cs_q && a_clk_q && !clk_a && a_rises == 0)
                check("a_first_fall", 32'(a_cyc), 32'd4);
            if (!a_cs_q && !a_clk_q && clk_a) begin
                if (a_rises > 0) check("a_clk_period", 32'(a_cyc - a_last_rise), 32'd8);
                a_rises++;
                a_last_rise = a_cyc;
            end
            if (!a_cs_q && cs_a && a_win_ok) check("a_rises_per_frame", 32'(a_rises), 32'd16);
            if (valid_a) begin
                check("a_valid_width", 32'(a_v_q), 32'd0);
                a_valid_cnt++;
            end
            a_cs_q = cs_a; a_clk_q = clk_a; a_v_q = valid_a;
        end
    end

    // Protocol monitor and ramp scoreboard for instance B (CLK_DIV=1, QUIET_CLKS=1).
    int   b_cyc = 0, b_rises = 0, b_last_rise = 0, b_done = 0, b_rd = 0;
    bit   b_len_ok = 0, b_win_ok = 0;
    logic b_cs_q = 1'b1, b_clk_q = 1'b1, b_v_q = 1'b0;

    always @(negedge clock_in) begin
        if (!rst_b) begin
            b_len_ok = 0; b_win_ok = 0;
            b_cs_q = 1'b1; b_clk_q = 1'b1; b_v_q = 1'b0;
        end else begin
            b_cyc++;
            if (b_cs_q && !cs_b) begin
                if (b_len_ok) check("b_frame_len", 32'(b_cyc), 32'd33);
                b_cyc = 0; b_len_ok = 1; b_rises = 0; b_win_ok = 1;
            end
            if (!b_cs_q && b_clk_q && !clk_b && b_rises == 0)
                check("b_first_fall", 32'(b_cyc), 32'd1);
            if (!b_cs_q && !b_clk_q && clk_b) begin
                if (b_rises > 0) check("b_clk_period", 32'(b_cyc - b_last_rise), 32'd2);
                b_rises++;
                b_last_rise = b_cyc;
            end
            if (!b_cs_q && cs_b && b_win_ok) check("b_rises_per_frame", 32'(b_rises), 32'd16);
            if (valid_b) begin
                check("b_valid_width", 32'(b_v_q), 32'd0);
                if (b_rd < b_exp.size()) begin
                    check("b_ramp_sample", 32'(sample_b), 32'(b_exp[b_rd]));
                    b_rd++;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_valid actual=pulse required=no pulse without a completed frame");
                end
                b_done++;
            end
            b_cs_q = cs_b; b_clk_q = clk_b; b_v_q = valid_b;
        end
    end

    initial begin : drive_b
        #1 rst_b = 1'b0;
        repeat (2) @(negedge clock_in);
        rst_b = 1'b1;
    end

    task automatic wait_valid_a(input string name, output bit ok);
        int n = 0;
        ok = 0;
        while (n < 600) begin
            @(negedge clock_in);
            n++;
            if (valid_a) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_timeout(name);
    endtask

    task automatic run_frame_a(input string name, input logic [15:0] word, input logic [11:0] exp);
        bit ok;
        a_word = word;
        wait_valid_a(name, ok);
        if (ok) check(name, 32'(sample_a), 32'(exp));
    endtask

    task automatic wait_cs_fall_a(input string name, output int n);
        n = 0;
        while (cs_a && n < 400) begin
            @(negedge clock_in);
            n++;
        end
        if (cs_a) fail_timeout(name);
    endtask

    initial begin : main
        vec_t        vecs[7];
        logic [15:0] w;
        logic [11:0] e;
        logic        prev;
        int          n, r, v_before;

        vecs[0] = '{word: 16'h0ABC, exp: 12'hABC};
        vecs[1] = '{word: 16'hFFFF, exp: 12'hFFF};
        vecs[2] = '{word: 16'h0000, exp: 12'h000};
        vecs[3] = '{word: 16'hF123, exp: 12'h123};
        vecs[4] = '{word: 16'h5A5A, exp: 12'hA5A};
        vecs[5] = '{word: 16'h8001, exp: 12'h001};
        vecs[6] = '{word: 16'h7FFE, exp: 12'hFFE};

        #1 rst_a = 1'b0;
        repeat (3) @(negedge clock_in);
        check("rst_cs", 32'(cs_a), 32'd1);
        check("rst_clk", 32'(clk_a), 32'd1);
        check("rst_sample", 32'(sample_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);

        a_word = vecs[0].word;
        rst_a = 1'b1;
        wait_cs_fall_a("a_first_cs_fall", n);
        check("a_rst_to_cs_fall", 32'(n), 32'd16);

        for (int i = 0; i < 7; i++)
            run_frame_a($sformatf("a_vec%0d", i), vecs[i].word, vecs[i].exp);

        for (int i = 0; i < 20; i++) begin
            w = 16'($urandom);
            e = 12'(w % 16'd4096);
            run_frame_a("a_random", w, e);
        end

        // Abort a frame after its 8th rising adc_clk edge.
        a_word = 16'h0FED;
        wait_cs_fall_a("a_abort_cs_fall", n);
        r = 0;
        n = 0;
        prev = clk_a;
        while (r < 8 && n < 400) begin
            @(negedge clock_in);
            n++;
            if (!prev && clk_a) r++;
            prev = clk_a;
        end
        if (r < 8) fail_timeout("a_abort_rises");
        repeat (5) @(negedge clock_in);
        check("a_pre_abort_cs", 32'(cs_a), 32'd0);
        check("a_pre_abort_clk", 32'(clk_a), 32'd0);
        v_before = a_valid_cnt;
        #2 rst_a = 1'b0;
        #1;
        check("a_abort_cs_async", 32'(cs_a), 32'd1);
        check("a_abort_clk_async", 32'(clk_a), 32'd1);
        check("a_abort_sample", 32'(sample_a), 32'd0);
        repeat (3) @(negedge clock_in);
        a_word = 16'h0123;
        rst_a = 1'b1;
        wait_cs_fall_a("a_rerun_cs_fall", n);
        check("a_rerun_rst_to_cs_fall", 32'(n), 32'd16);
        run_frame_a("a_after_abort", 16'h0123, 12'h123);
        @(negedge clock_in);
        check("a_abort_valid_count", 32'(a_valid_cnt - v_before), 32'd1);
        check("a_valid_dropped", 32'(valid_a), 32'd0);

        n = 0;
        while (b_done < 1000 && n < 40000) begin
            @(negedge clock_in);
            n++;
        end
        check("b_ramp_count", 32'(b_done), 32'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per adc_clk half-period; legal range 1..255.
REQ-002 Parameter QUIET_CLKS, default 16: system clocks adc_cs stays high between conversions; legal range 1..1023.
REQ-003 Port clock_in, input, 1 bit: system clock, the only clock.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port adc_cs, output, 1 bit: ADC chip select, active low.
REQ-006 Port adc_clk, output, 1 bit: ADC serial clock; idles high.
REQ-007 Port adc_sd, input, 1 bit: ADC serial data, MSB first.
REQ-008 Port sample, output, 12 bits: last completed conversion result.
REQ-009 Port sample_valid, output, 1 bit: one-clock_in pulse when sample updates.

Function
REQ-010 FSM states: QUIET, FRAME; free-running after reset, with no start input.
REQ-011 QUIET: adc_cs=1, adc_clk=1; after QUIET_CLKS clock_in cycles go to FRAME, drive adc_cs=0.
REQ-012 FRAME: adc_clk toggles every CLK_DIV clock_in cycles, starting low, giving exactly 16 full adc_clk periods.
REQ-013 First adc_clk falling edge occurs CLK_DIV cycles after adc_cs falls.
REQ-014 adc_sd is sampled in the clock_in cycle in which adc_clk is driven from 0 to 1 (rising edge).
REQ-015 Bits are shifted MSB first into a 16-bit shift register.
REQ-016 After the 16th rising edge: adc_clk returns high, adc_cs goes high in the same cycle, and FSM enters QUIET.
REQ-017 On FRAME exit: sample <= shift register bits [11:0]; the 4 leading bits are discarded with no checking.
REQ-018 sample_valid is high exactly one clock_in cycle, coincident with the sample update.
REQ-019 Frame length: QUIET_CLKS + 32*CLK_DIV clock_in cycles (default 144).
REQ-020 adc_sd is passed through a 2-flop synchronizer; the sampling point compensates so the bit captured is the value present at the rising adc_clk edge.
REQ-021 All outputs are registered; no combinational path from adc_sd to any output.
REQ-022 Bit counter is 5 bits wide and saturates at 16; it does not wrap within a frame.

Reset
REQ-023 While reset=0: adc_cs=1, adc_clk=1, sample=0, sample_valid=0, FSM=QUIET, all counters cleared.
REQ-024 Assertion mid-FRAME aborts the frame immediately: no sample_valid pulse, and the partial data is dropped.
REQ-025 After reset release, the first adc_cs fall occurs QUIET_CLKS cycles later.

Structure
REQ-026 Shared package holds constants ADC_FRAME_BITS=16, ADC_DATA_BITS=12, ADC_LEAD_ZEROS=4, and the FSM state typedef.
REQ-027 One sub-module, adc_clk_gen, produces the adc_clk level and the rise/fall strobes from CLK_DIV; top holds the FSM and the shift register.

Verification
REQ-028 Serial-slave model returns 0x0ABC (16 bits, MSB first on falling adc_clk) -> sample=0xABC, a single sample_valid pulse.
REQ-029 Defaults: count clock_in cycles between adc_cs falls -> exactly 144; exactly 16 adc_clk rising edges per low adc_cs window.
REQ-030 Slave returns 0xFFFF then 0x0000 on consecutive frames -> sample=0xFFF then 0x000; leading bits ignored.
REQ-031 Reset asserted after the 8th rising edge of a frame -> adc_cs=1 and adc_clk=1 asynchronously, no sample_valid; next frame completes normally.
REQ-032 CLK_DIV=1, QUIET_CLKS=1 -> adc_clk period 2 clock_in cycles, frame length 33 cycles, data still captured correctly.
REQ-033 adc_sd held at X while adc_cs=1 -> sample unaffected; 1000 frames of ramp data 0..999 -> every sample matches.
